// File: rtl/fsel_sched.sv
// fsel_sched: debounced filter-select scheduler applying masks on frame starts with a pass-through settle window
module fsel_sched #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_FRAMES = 2,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_i,
  input  logic       vsync_i,
  output logic [3:0] fsel_o,
  output logic [3:0] out_sel_o,
  output logic       busy_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PEND, SETTLE} state_t;
  state_t state, state_n;
  logic [3:0] sw_m, sw_s, cand, sw_db, sfc, sfc_n, fsel_n, out_n;
  logic [CW-1:0] cnt;
  logic vs_m, vs_s, vs_d, fs, chg, apply, done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sw_m, sw_s, cand, sw_db} <= '0;
      {vs_m, vs_s, vs_d} <= '0;
      cnt <= '0;
    end else begin
      sw_m <= sw_i;
      sw_s <= sw_m;
      vs_m <= vsync_i ^ ~VSYNC_POL;
      vs_s <= vs_m;
      vs_d <= vs_s;
      if (sw_s != cand) begin
        cand <= sw_s;
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) sw_db <= cand;
      else cnt <= cnt + CW'(1);
    end
  end
  assign fs = vs_s & ~vs_d;
  assign chg = sw_db != fsel_o;
  // a zero mask needs no settle window since the mux already passes through
  always_comb begin
    apply = chg && fs && state != SETTLE;
    done = state == SETTLE && fs && sfc == 4'd1;
    state_n = apply ? (sw_db == '0 ? IDLE : SETTLE) :
              state == SETTLE ? (done ? IDLE : SETTLE) : chg ? PEND : IDLE;
    fsel_n = apply ? sw_db : fsel_o;
    out_n = apply ? '0 : done ? fsel_o : out_sel_o;
    sfc_n = apply && sw_db != '0 ? 4'(SETTLE_FRAMES) :
            state == SETTLE && fs ? sfc - 4'd1 : sfc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fsel_o <= '0;
      out_sel_o <= '0;
      sfc <= '0;
      busy_o <= 1'b0;
    end else begin
      state <= state_n;
      fsel_o <= fsel_n;
      out_sel_o <= out_n;
      sfc <= sfc_n;
      busy_o <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_fsel_sched.sv
// tb_fsel_sched: randomized scoreboard bench for fsel_sched against a window/frame-level reference model
module tb_fsel_sched;
  localparam int DB = 4;
  localparam int SF = 2;
  logic clk = 1'b0, rst_n = 1'b0, vsync_i = 1'b0;
  logic [3:0] sw_i = 4'b0011;
  logic [3:0] fsel_o, out_sel_o;
  logic busy_o;
  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {int cyc; logic [3:0] f; logic [3:0] o; logic b;} exp_t;
  exp_t q[$];

  fsel_sched #(.DEBOUNCE_CYCLES(DB), .SETTLE_FRAMES(SF), .VSYNC_POL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sw_i(sw_i), .vsync_i(vsync_i),
    .fsel_o(fsel_o), .out_sel_o(out_sel_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, a, e, cyc);
    end
  endtask

  // Reference model: switches are accepted once the synchronized samples have been
  // equal over a DB+1 sample window; masks change only on frame starts.
  logic [3:0] h [DB+2];
  logic v [3];
  logic [3:0] db = '0, mf = '0, mo = '0, pf = '0, po = '0;
  logic mb = 1'b0, pb = 1'b0, settling = 1'b0, rst_q = 1'b0;
  int rem = 0;

  task automatic mreset();
    for (int i = 0; i < DB + 2; i++) h[i] = '0;
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    db = '0; mf = '0; mo = '0; mb = 1'b0; settling = 1'b0; rem = 0;
  endtask

  task automatic mstep();
    logic frame, eq;
    frame = v[1] & ~v[2];
    if (settling) begin
      if (frame) begin
        rem--;
        if (rem == 0) begin mo = mf; settling = 1'b0; end
      end
      mb = settling;
    end else if (db != mf && frame) begin
      mf = db; mo = '0; settling = db != '0; rem = SF; mb = settling;
    end else mb = db != mf;
    eq = 1'b1;
    for (int i = 2; i <= DB + 1; i++) if (h[i] != h[1]) eq = 1'b0;
    if (eq) db = h[1];
    for (int i = DB + 1; i >= 1; i--) h[i] = h[i-1];
    h[0] = sw_i;
    v[2] = v[1]; v[1] = v[0]; v[0] = vsync_i;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_q && !rst_n) mreset();
      else begin
        cyc++;
        if (!rst_n) mreset();
        else mstep();
      end
      rst_q = rst_n;
      if ({mf, mo, mb} != {pf, po, pb}) begin
        q.push_back('{cyc, mf, mo, mb});
        {pf, po, pb} = {mf, mo, mb};
      end
    end
  end

  initial begin
    logic [8:0] last, cur;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk);
      cur = {fsel_o, out_sel_o, busy_o};
      if (cur !== last) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL out_change: unexpected f=%h o=%h b=%b at cyc %0d", fsel_o, out_sel_o, busy_o, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== {e.f, e.o, e.b} || cyc != e.cyc) begin
            mismatched++;
            $display("FAIL out_change: got f=%h o=%h b=%b at cyc %0d, want f=%h o=%h b=%b at cyc %0d",
                     fsel_o, out_sel_o, busy_o, cyc, e.f, e.o, e.b, e.cyc);
          end
        end
        if (out_sel_o != '0) chk("outsel_eq_fsel", out_sel_o, fsel_o);
        last = cur;
      end
    end
  end

  initial begin
    forever begin
      vsync_i = 1'b1;
      repeat (5) @(posedge clk);
      #1 vsync_i = 1'b0;
      repeat (95) @(posedge clk);
      #1;
    end
  end

  task automatic hold(input logic [3:0] val, input int n);
    sw_i = val;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fsel(input logic [3:0] val);
    int n = 0;
    while (fsel_o !== val && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fsel", fsel_o, val);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fsel", fsel_o, 4'h0);
    chk("rst_out", out_sel_o, 4'h0);
    chk("rst_busy", {3'b0, busy_o}, 4'h0);
    rst_n = 1'b1;
    hold(4'b0011, 400);
    chk("boot_fsel", fsel_o, 4'b0011);
    chk("boot_out", out_sel_o, 4'b0011);
    hold(4'h0, 300);
    for (int i = 0; i < 10; i++) hold(i[0] ? 4'h0 : 4'h1, 3);
    hold(4'h1, 400);
    chk("bounce_fsel", fsel_o, 4'h1);
    chk("bounce_out", out_sel_o, 4'h1);
    hold(4'h0, 300);
    @(posedge vsync_i);
    hold(4'b0100, 20);
    chk("cancel_pend", {3'b0, busy_o}, 4'h1);
    hold(4'h0, 40);
    chk("cancel_idle", {3'b0, busy_o}, 4'h0);
    chk("cancel_fsel", fsel_o, 4'h0);
    hold(4'b1000, 400);
    chk("zero_pre_out", out_sel_o, 4'b1000);
    hold(4'h0, 200);
    chk("zero_fsel", fsel_o, 4'h0);
    chk("zero_busy", {3'b0, busy_o}, 4'h0);
    sw_i = 4'b0001;
    wait_fsel(4'b0001);
    @(posedge clk);
    #1;
    hold(4'b0010, 10);
    chk("settle_out0", out_sel_o, 4'h0);
    hold(4'b0010, 600);
    chk("settle2_fsel", fsel_o, 4'b0010);
    chk("settle2_out", out_sel_o, 4'b0010);
    sw_i = 4'b0100;
    wait_fsel(4'b0100);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fsel", fsel_o, 4'h0);
    chk("arst_out", out_sel_o, 4'h0);
    chk("arst_busy", {3'b0, busy_o}, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    hold(4'b0100, 400);
    chk("rearm_fsel", fsel_o, 4'b0100);
    chk("rearm_out", out_sel_o, 4'b0100);
    for (int i = 0; i < 60; i++)
      hold(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : $urandom_range(20, 300));
    hold(sw_i, 500);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: %0d expected changes never seen", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
